// File: rtl/pattern_scan_pkg.sv
// Shared constants and types for the byte-wise 10110 pattern scanner:
// controller and detector state encodings, widths and a saturating add.
package pattern_scan_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 2;
    localparam int HITS_W = 8;
    localparam int BIT_W  = 3;

    localparam logic [BIT_W-1:0] BIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_e;

    // Detector states are named after the longest matched prefix of 10110.
    typedef enum logic [2:0] {
        D_S0    = 3'd0,
        D_S1    = 3'd1,
        D_S10   = 3'd2,
        D_S101  = 3'd3,
        D_S1011 = 3'd4
    } det_state_e;

    function automatic logic [HITS_W-1:0] sat_add_hits(
        input logic [HITS_W-1:0] acc,
        input logic [CNT_W-1:0]  inc
    );
        logic [HITS_W:0] sum;
        sum = {1'b0, acc} + {{(HITS_W + 1 - CNT_W){1'b0}}, inc};
        return sum[HITS_W] ? {HITS_W{1'b1}} : sum[HITS_W-1:0];
    endfunction

endpackage

// File: rtl/seq10110_core.sv
// Serial Mealy detector for 10110 with overlap; after a hit it resumes
// from S10 because the trailing "10" is also a valid prefix.
module seq10110_core
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic hit
);

    det_state_e state_q;
    det_state_e state_d;

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (clr) begin
            state_d = D_S0;
        end else if (en) begin
            case (state_q)
                D_S0:    state_d = x ? D_S1    : D_S0;
                D_S1:    state_d = x ? D_S1    : D_S10;
                D_S10:   state_d = x ? D_S101  : D_S0;
                D_S101:  state_d = x ? D_S1011 : D_S10;
                D_S1011: begin
                    state_d = x ? D_S1 : D_S10;
                    hit     = ~x;
                end
                default: state_d = D_S0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= D_S0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Round-robin byte acceptor that scans each granted byte MSB-first for 10110
// and reports a per-byte hit count plus a saturating running total.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [BYTE_W-1:0]   req_data0,
    input  logic [BYTE_W-1:0]   req_data1,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    output logic                res_src,
    output logic [CNT_W-1:0]    res_cnt,
    output logic [HITS_W-1:0]   total_hits,
    output logic                busy,
    output ctrl_state_e         dbg_state
);

    // Handshake: a byte moves when req_valid[i] && req_ready[i] at a rising
    // edge; req_ready is only ever raised in IDLE and is one-hot.
    ctrl_state_e         state_q,      state_d;
    logic [BYTE_W-1:0]   shreg_q,      shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                src_q,        src_d;
    logic                last_grant_q, last_grant_d;
    logic                res_valid_q,  res_valid_d;
    logic                res_src_q,    res_src_d;
    logic [CNT_W-1:0]    res_cnt_q,    res_cnt_d;
    logic [HITS_W-1:0]   total_q,      total_d;

    logic                any_valid;
    logic                grant_idx;
    logic                core_clr;
    logic                core_en;
    logic                core_hit;
    logic [CNT_W-1:0]    cnt_sum;

    assign any_valid = |req_valid;

    // Contention goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        if (&req_valid) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req_valid[1];
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && any_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign core_clr = (state_q == ST_IDLE) && any_valid;
    assign core_en  = (state_q == ST_SHIFT);
    assign cnt_sum  = cnt_q + {{(CNT_W - 1){1'b0}}, core_hit};

    seq10110_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (core_clr),
        .en    (core_en),
        .x     (shreg_q[BYTE_W-1]),
        .hit   (core_hit)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        res_valid_d  = 1'b0;
        res_src_d    = res_src_q;
        res_cnt_d    = res_cnt_q;
        total_d      = total_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d      = ST_SHIFT;
                    shreg_d      = grant_idx ? req_data1 : req_data0;
                    bit_cnt_d    = '0;
                    cnt_d        = '0;
                    src_d        = grant_idx;
                    last_grant_d = grant_idx;
                end
            end
            ST_SHIFT: begin
                shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                cnt_d     = cnt_sum;
                // The last bit's Mealy hit must be folded in here, not a cycle later.
                if (bit_cnt_q == BIT_LAST) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_src_d   = src_q;
                    res_cnt_d   = cnt_sum;
                    total_d     = sat_add_hits(total_q, cnt_sum);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_src_q    <= 1'b0;
            res_cnt_q    <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_src_q    <= res_src_d;
            res_cnt_q    <= res_cnt_d;
            total_q      <= total_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_src    = res_src_q;
    assign res_cnt    = res_cnt_q;
    assign total_hits = total_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [7:0]  req_data0 = 8'h00;
  logic [7:0]  req_data1 = 8'h00;
  logic [1:0]  req_ready;
  logic        res_valid;
  logic        res_src;
  logic [1:0]  res_cnt;
  logic [7:0]  total_hits;
  logic        busy;
  ctrl_state_e dbg_state;

  pattern_scan_ctrl #(.NREQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_src    (res_src),
    .res_cnt    (res_cnt),
    .total_hits (total_hits),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Overlapping occurrences of 10110 in an MSB-first byte are exactly the
  // 5-bit windows equal to 5'b10110.
  function automatic int count_10110(input logic [7:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (((b >> (3 - i)) & 8'h1f) == 8'h16) n++;
    end
    return n;
  endfunction

  // m_age: 0 = no byte in flight, k = k cycles since the accept edge (1..9).
  int         m_age   = 0;
  logic [7:0] m_byte  = 8'h00;
  logic       m_src   = 1'b0;
  logic       m_last  = 1'b1;
  int         m_total = 0;
  logic [1:0] m_ready;
  logic       m_pick;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (reset) begin
      m_age   = 0;
      m_last  = 1'b1;
      m_total = 0;
      exp_q.delete();
    end
    m_ready = 2'b00;
    m_pick  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
    if (m_age == 0 && req_valid != 2'b00) m_ready[m_pick] = 1'b1;

    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("res_valid", 32'(res_valid), 32'(m_age == 9));
    chk("total_hits", 32'(total_hits), 32'(m_total));
    if (m_age == 9) begin
      chk("res_src", 32'(res_src), 32'(m_src));
      chk("res_cnt", 32'(res_cnt), 32'(count_10110(m_byte)));
    end

    if (!reset) begin
      if (m_age == 0) begin
        if (req_valid != 2'b00) begin
          m_src  = m_pick;
          m_last = m_pick;
          m_byte = m_pick ? req_data1 : req_data0;
          exp_q.push_back(m_byte);
          m_age  = 1;
        end
      end else if (m_age == 8) begin
        m_total = (m_total + count_10110(m_byte) > 255) ? 255 : m_total + count_10110(m_byte);
        m_age   = 9;
      end else if (m_age == 9) begin
        void'(exp_q.pop_front());
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic offer(input int idx, input logic [7:0] d);
    int n;
    req_valid = 2'b00;
    req_valid[idx] = 1'b1;
    if (idx == 0) req_data0 = d; else req_data1 = d;
    n = 0;
    #1;
    while (!req_ready[idx] && n < 20) begin
      step();
      #1;
      n++;
    end
    if (n >= 20) chk("offer_timeout", 32'(req_ready), 32'(2'b01 << idx));
    step();
    req_valid = 2'b00;
  endtask

  // Scrambles the request bytes every cycle so a late change would show up.
  task automatic wait_res(input string tag, input int e_src, input int e_cnt, input int e_total);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      req_data0 = 8'($urandom);
      req_data1 = 8'($urandom);
      step();
      n++;
    end
    if (!res_valid) begin
      chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
    end else begin
      chk({tag, "_src"}, 32'(res_src), 32'(e_src));
      chk({tag, "_cnt"}, 32'(res_cnt), 32'(e_cnt));
      chk({tag, "_total"}, 32'(total_hits), 32'(e_total));
    end
    step();
  endtask

  // ---------------- stimulus ----------------
  int g_cyc[$];
  int g_idx[$];

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_total", 32'(total_hits), 32'd0);
    step();
    reset = 1'b0;

    // Single byte B6 -> two overlapping hits.
    offer(0, 8'hB6);
    wait_res("b6", 0, 2, 2);

    // Requester 1 alone: 16, 2C, FF.
    do_reset();
    offer(1, 8'h16);
    wait_res("r1_16", 1, 1, 1);
    offer(1, 8'h2C);
    wait_res("r1_2c", 1, 1, 2);
    offer(1, 8'hFF);
    wait_res("r1_ff", 1, 0, 2);

    // Both valid from reset: grants 0,1,0,1 ten cycles apart.
    reset = 1'b1;
    req_valid = 2'b11;
    req_data0 = 8'hB6;
    req_data1 = 8'h16;
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready != 2'b00) begin
        g_cyc.push_back(c);
        g_idx.push_back(req_ready[1] ? 1 : 0);
      end
      step();
      #1;
    end
    req_valid = 2'b00;
    chk("rr_grants", 32'(g_cyc.size()), 32'd4);
    for (int k = 0; k < 4 && k < g_cyc.size(); k++) begin
      chk("rr_idx", 32'(g_idx[k]), 32'(k % 2));
      chk("rr_cycle", 32'(g_cyc[k]), 32'(10 * k));
    end
    repeat (12) step();

    // Reset at T+4 of a B6 transfer.
    do_reset();
    req_valid = 2'b01;
    req_data0 = 8'hB6;
    step();
    req_valid = 2'b00;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_total", 32'(total_hits), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    req_valid = 2'b11;
    req_data0 = 8'hB6;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_next_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    wait_res("midrst_after", 0, 2, 2);

    // Saturation: 128+ transfers of B6.
    do_reset();
    req_valid = 2'b01;
    req_data0 = 8'hB6;
    repeat (1285) step();
    req_valid = 2'b00;
    repeat (12) step();
    chk("sat_total", 32'(total_hits), 32'd255);

    // Randomized traffic with occasional reset pulses.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = ($urandom_range(0, 3) == 0) ? 8'hB6 : 8'($urandom);
      req_data1 = ($urandom_range(0, 3) == 0) ? 8'h16 : 8'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    req_valid = 2'b00;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 The block SHALL have a parameter NREQ, default 2, giving the number of requesters (fixed at 2 in this release).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2, per-requester byte-offer flag.
REQ-005 The block SHALL have port req_data0, input, 8, requester 0 byte.
REQ-006 The block SHALL have port req_data1, input, 8, requester 1 byte.
REQ-007 The block SHALL have port req_ready, output, 2, one-hot grant; a byte transfers when req_valid[i] && req_ready[i].
REQ-008 The block SHALL have port res_valid, output, 1, one-cycle result pulse.
REQ-009 The block SHALL have port res_src, output, 1, index of the requester whose byte produced the result.
REQ-010 The block SHALL have port res_cnt, output, 2, number of 10110 occurrences found in the byte.
REQ-011 The block SHALL have port total_hits, output, 8, saturating count of all occurrences since reset.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with at least one req_valid set, the FSM SHALL grant one requester, assert its req_ready combinationally in that cycle, load the byte, clear the bit counter and go to SHIFT.
REQ-015 In every state other than IDLE, req_ready SHALL be 2'b00.
REQ-016 Arbitration SHALL be round-robin.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - last_grant resets to 1, so requester 0 wins the first contention.
REQ-017 SHIFT SHALL last exactly 8 cycles and feed the byte MSB-first, one bit per cycle, to the detector core.
REQ-018 The detector core SHALL be cleared to its initial state at byte load, so every byte is scanned independently.
REQ-019 Detection SHALL be Mealy with overlap allowed.
  - A hit is signalled when the core is in state S1011 and the input bit is 0.
  - After a hit the core moves to state S10, so 10110110 yields 2 hits.
REQ-020 The per-byte hit count SHALL be 2 bits wide; its maximum possible value is 2, so it cannot overflow.
REQ-021 After the 8th shift cycle the FSM SHALL enter DONE for one cycle with registered outputs.
  - res_valid=1, res_src and res_cnt valid.
  - total_hits updated in the same cycle.
  - Next state is IDLE.
REQ-022 Timing SHALL be as follows for a transfer accepted at cycle T.
  - Shift cycles are T+1..T+8.
  - res_valid is high at T+9.
  - The earliest next accept is T+10.
REQ-023 total_hits SHALL saturate at 255 and never wrap.
REQ-024 A change on req_valid or req_data during SHIFT or DONE SHALL have no effect.
REQ-025 Results SHALL have no backpressure; res_valid is a pulse whether or not it is consumed.

Reset
REQ-026 When reset is asserted, asynchronously and regardless of clk, the block SHALL take these values.
  - State IDLE; req_ready=0; res_valid=0; res_src=0; res_cnt=0.
  - total_hits=0; busy=0; last_grant=1; detector core in its initial state.
REQ-027 A reset asserted during SHIFT or DONE SHALL discard the byte in progress, and no res_valid SHALL follow for that byte.
REQ-028 After reset is released, the first grant SHALL be possible on the first clk edge.

Structure
REQ-029 The shared package pattern_scan_pkg SHALL hold these constants.
  - FSM state encodings (IDLE/SHIFT/DONE).
  - Detector state encodings.
  - BYTE_W=8, CNT_W=2, HITS_W=8.
REQ-030 The serial detector SHALL be a sub-module named seq10110_core.
  - Ports: clk, reset, clr, en, x, hit.
  - hit is combinational Mealy.
REQ-031 The arbiter, shift register, bit counter and result registers SHALL reside in pattern_scan_ctrl.

Verification
REQ-032 Scenario: req_valid=01, req_data0=8'hB6 -> req_ready=01 at T; res_valid at T+9 with res_src=0, res_cnt=2; total_hits=2.
REQ-033 Scenario: req_data1=8'h16, then 8'h2C, then 8'hFF, each offered singly -> res_cnt=1, then 1, then 0; total_hits accumulates to 2.
REQ-034 Scenario: both valid continuously from reset -> grants alternate 0,1,0,1 at 10-cycle spacing.
REQ-035 Scenario: reset pulsed at T+4 of a transfer of 8'hB6 -> no res_valid; total_hits=0; busy=0 immediately; the next grant goes to requester 0.
REQ-036 Scenario: 128 transfers of 8'hB6 -> total_hits holds at 255 and does not wrap.
REQ-037 Scenario: req_data changed during SHIFT -> res_cnt reflects only the byte captured at accept.
